mlt3_decoder: RTL and testbench

- Receive-side stage that consumes the 2-bit MLT-3 line symbols produced by the team's MLT-3 coder.
- Recovers the serial data stream: a bit is 1 when the line level changes and 0 when it holds.
- Checks MLT-3 level-ordering legality and counts code violations.
- Deserializes recovered bits LSB-first into WIDTH-bit words with a single-cycle valid strobe for the downstream byte sink.

---
 rtl/mlt3_decoder.sv | 147 ++++++++++++++
 tb/tb_mlt3_decoder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mlt3_decoder.sv
// MLT-3 receive decoder: recovers the serial bit stream from 2-bit line
// symbols, flags level-ordering violations with a saturating counter, and
// deserializes the recovered bits LSB-first into WIDTH-bit words.
module mlt3_decoder #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       sym,
    input  logic             align,
    input  logic             err_clr,
    output logic             bit_out,
    output logic             bit_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

    localparam logic [1:0] SYM_ZERO = 2'b00;
    localparam logic [1:0] SYM_NEG  = 2'b01;
    localparam logic [1:0] SYM_ILL  = 2'b11;

    logic [1:0]       prev_sym_r;
    logic [1:0]       last_nz_r;
    logic [CNT_W-1:0] bit_cnt_r;
    logic [WIDTH-1:0] shift_r;

    logic             bit_s;
    logic             viol_s;
    logic             accept_s;
    logic [WIDTH-1:0] word_s;

    // Classify the incoming symbol against the previous level and the last
    // nonzero level to recover the bit and detect ordering violations.
    always_comb begin
        bit_s    = 1'b0;
        viol_s   = 1'b0;
        accept_s = 1'b1;
        if (sym == SYM_ILL) begin
            // Not a line level at all: report it and keep the old context.
            bit_s    = 1'b0;
            viol_s   = 1'b1;
            accept_s = 1'b0;
        end else if (sym == prev_sym_r) begin
            bit_s  = 1'b0;
            viol_s = 1'b0;
        end else if (sym == SYM_ZERO) begin
            // Returning to zero from either rail is always legal.
            bit_s  = 1'b1;
            viol_s = 1'b0;
        end else if (prev_sym_r == SYM_ZERO) begin
            // Leaving zero must go to the rail opposite the last one visited.
            bit_s  = 1'b1;
            viol_s = (sym == last_nz_r);
        end else begin
            // Direct rail-to-rail jump skips the zero level.
            bit_s  = 1'b1;
            viol_s = 1'b1;
        end
    end

    // Partial word with the current bit inserted at its position.
    always_comb begin
        word_s            = shift_r;
        word_s[bit_cnt_r] = bit_s;
    end

    // Line-state tracking and per-symbol bit/error strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_sym_r <= SYM_ZERO;
            last_nz_r  <= SYM_NEG;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            err        <= 1'b0;
        end else if (en) begin
            bit_out   <= bit_s;
            bit_valid <= 1'b1;
            err       <= viol_s;
            if (accept_s) begin
                prev_sym_r <= sym;
                if (sym != SYM_ZERO) begin
                    last_nz_r <= sym;
                end else begin
                    last_nz_r <= last_nz_r;
                end
            end else begin
                prev_sym_r <= prev_sym_r;
                last_nz_r  <= last_nz_r;
            end
        end else begin
            bit_out   <= bit_out;
            bit_valid <= 1'b0;
            err       <= 1'b0;
        end
    end

    // Saturating violation counter; a clear request beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (en && viol_s && (err_cnt != ERR_MAX)) begin
            err_cnt <= err_cnt + ERR_ONE;
        end else begin
            err_cnt <= err_cnt;
        end
    end

    // LSB-first deserializer with word-alignment restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r  <= '0;
            shift_r    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (align) begin
            bit_cnt_r  <= '0;
            shift_r    <= '0;
            dout_valid <= 1'b0;
        end else if (en) begin
            if (bit_cnt_r == LAST_IDX) begin
                dout       <= word_s;
                dout_valid <= 1'b1;
                bit_cnt_r  <= '0;
                shift_r    <= '0;
            end else begin
                shift_r    <= word_s;
                bit_cnt_r  <= bit_cnt_r + CNT_ONE;
                dout_valid <= 1'b0;
            end
        end else begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mlt3_decoder.sv
// Directed testbench for mlt3_decoder: two instances share all inputs, one
// with the default 8-bit error counter and one with a 2-bit counter to show
// saturation.
module tb_mlt3_decoder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] sym;
    logic       align;
    logic       err_clr;

    logic       bit_out8, bit_valid8, dout_valid8, err8;
    logic [7:0] dout8;
    logic [7:0] err_cnt8;

    logic       bit_out2, bit_valid2, dout_valid2, err2;
    logic [7:0] dout2;
    logic [1:0] err_cnt2;

    int checks_cnt;
    int errors_cnt;

    mlt3_decoder #(.WIDTH(8), .ERR_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .sym(sym), .align(align),
        .err_clr(err_clr), .bit_out(bit_out8), .bit_valid(bit_valid8),
        .dout(dout8), .dout_valid(dout_valid8), .err(err8), .err_cnt(err_cnt8)
    );

    mlt3_decoder #(.WIDTH(8), .ERR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .sym(sym), .align(align),
        .err_clr(err_clr), .bit_out(bit_out2), .bit_valid(bit_valid2),
        .dout(dout2), .dout_valid(dout_valid2), .err(err2), .err_cnt(err_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs at negedge, return 1 time unit after posedge.
    task automatic step(input logic [1:0] s, input logic e, input logic a, input logic c);
        @(negedge clk);
        sym = s; en = e; align = a; err_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0; sym = 2'b00; align = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_dout", {24'd0, dout8}, 32'd0);
        check("rst_dv", {31'd0, dout_valid8}, 32'd0);
        check("rst_bv", {31'd0, bit_valid8}, 32'd0);
        check("rst_err", {31'd0, err8}, 32'd0);
        check("rst_errcnt", {24'd0, err_cnt8}, 32'd0);
        rst_n = 1'b1;
    endtask

    // Send 8 symbols (index i at syms[2i+:2]); check each recovered bit and
    // that exactly the eighth cycle strobes the finished word.
    task automatic run_word(input string tag, input logic [15:0] syms,
                            input logic [7:0] exp_word);
        for (int i = 0; i < 8; i++) begin
            step(syms[2*i +: 2], 1'b1, 1'b0, 1'b0);
            check({tag, "_bit"}, {31'd0, bit_out8}, {31'd0, exp_word[i]});
            check({tag, "_bv"}, {31'd0, bit_valid8}, 32'd1);
            check({tag, "_err"}, {31'd0, err8}, 32'd0);
            check({tag, "_dv"}, {31'd0, dout_valid8}, (i == 7) ? 32'd1 : 32'd0);
        end
        check({tag, "_dout"}, {24'd0, dout8}, {24'd0, exp_word});
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst_n = 1'b0; en = 1'b0; sym = 2'b00; align = 1'b0; err_clr = 1'b0;

        // Basic decode: 10,10,00,00,00,01,01,00 -> A5
        do_reset();
        run_word("a5", {2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10}, 8'hA5);
        step(2'b00, 1'b0, 1'b0, 1'b0);
        check("idle_bv", {31'd0, bit_valid8}, 32'd0);
        check("idle_dv", {31'd0, dout_valid8}, 32'd0);
        check("idle_hold", {24'd0, dout8}, 32'h0000_00A5);

        // Rail-to-rail jump is a violation; following return to zero is legal
        do_reset();
        step(2'b10, 1'b1, 1'b0, 1'b0);
        check("jmp0_bit", {31'd0, bit_out8}, 32'd1);
        check("jmp0_err", {31'd0, err8}, 32'd0);
        step(2'b01, 1'b1, 1'b0, 1'b0);
        check("jmp1_bit", {31'd0, bit_out8}, 32'd1);
        check("jmp1_err", {31'd0, err8}, 32'd1);
        check("jmp1_cnt", {24'd0, err_cnt8}, 32'd1);
        step(2'b00, 1'b1, 1'b0, 1'b0);
        check("jmp2_bit", {31'd0, bit_out8}, 32'd1);
        check("jmp2_err", {31'd0, err8}, 32'd0);
        check("jmp2_cnt", {24'd0, err_cnt8}, 32'd1);

        // Illegal symbol holds previous level
        do_reset();
        step(2'b10, 1'b1, 1'b0, 1'b0);
        step(2'b11, 1'b1, 1'b0, 1'b0);
        check("ill_bit", {31'd0, bit_out8}, 32'd0);
        check("ill_err", {31'd0, err8}, 32'd1);
        step(2'b00, 1'b1, 1'b0, 1'b0);
        check("ill_next_bit", {31'd0, bit_out8}, 32'd1);
        check("ill_next_err", {31'd0, err8}, 32'd0);

        // Saturation on the 2-bit counter, then clear beating a violation
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(2'b11, 1'b1, 1'b0, 1'b0);
            check("sat_err", {31'd0, err2}, 32'd1);
            check("sat_cnt2", {30'd0, err_cnt2}, (i < 3) ? (i + 1) : 32'd3);
            check("sat_cnt8", {24'd0, err_cnt8}, i + 1);
        end
        step(2'b11, 1'b1, 1'b0, 1'b1);
        check("clr_err", {31'd0, err2}, 32'd1);
        check("clr_cnt2", {30'd0, err_cnt2}, 32'd0);
        check("clr_cnt8", {24'd0, err_cnt8}, 32'd0);

        // Align after three bits, then a clean 3C word
        do_reset();
        step(2'b10, 1'b1, 1'b0, 1'b0);
        step(2'b10, 1'b1, 1'b0, 1'b0);
        step(2'b00, 1'b1, 1'b0, 1'b0);
        step(2'b00, 1'b1, 1'b1, 1'b0);
        check("aln_bv", {31'd0, bit_valid8}, 32'd1);
        check("aln_bit", {31'd0, bit_out8}, 32'd0);
        check("aln_dv", {31'd0, dout_valid8}, 32'd0);
        run_word("3c", {2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00}, 8'h3C);

        // Reset mid-word: error counter and word output cleared immediately
        step(2'b11, 1'b1, 1'b0, 1'b0);
        check("mid_errcnt_pre", {24'd0, err_cnt8}, 32'd1);
        step(2'b00, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b1, 1'b0, 1'b0);
        step(2'b00, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_dout", {24'd0, dout8}, 32'd0);
        check("mid_dv", {31'd0, dout_valid8}, 32'd0);
        check("mid_errcnt", {24'd0, err_cnt8}, 32'd0);
        check("mid_errcnt2", {30'd0, err_cnt2}, 32'd0);
        en = 1'b0;
        #2;
        rst_n = 1'b1;
        run_word("a5b", {2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10}, 8'hA5);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
